// File: rtl/alu_pkg.sv
// Shared types and reference model for the ALU command issuer.
// Optional ALU_SCOREBOARD_EN uses alu_ref() for in-line result checking.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int OPC_W = 3;
  localparam int ALU_IDW = 4;

  typedef enum logic [OPC_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
    alu_op_e            op;
    logic [ALU_IDW-1:0] id;
  } alu_req_t;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 2'd0;
  localparam fsm_state_t ST_SETTLE = 2'd1;
  localparam fsm_state_t ST_RESP   = 2'd2;

  // Returns {zero, result}; shifts use b[2:0] as the distance.
  function automatic logic [ALU_W:0] alu_ref(
    input logic [ALU_W-1:0] a,
    input logic [ALU_W-1:0] b,
    input alu_op_e          op
  );
    logic [ALU_W-1:0] r;
    r = '0;
    case (op)
      ADD: r = a + b;
      SUB: r = a - b;
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      SHL: r = a << b[2:0];
      SHR: r = a >> b[2:0];
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointers.
// full_nxt lets the owner register a ready that never overshoots.
module alu_req_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty,
  output logic full_nxt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] wn;
  logic [AW:0] rn;
  T            mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wn;
      rptr <= rn;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  assign wn = push ? wptr + (AW+1)'(1) : wptr;
  assign rn = pop  ? rptr + (AW+1)'(1) : rptr;

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign full_nxt = (wn[AW] != rn[AW]) &&
                    (wn[AW-1:0] == rn[AW-1:0]);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU requests, drives the ALU, returns tagged results.
// Define ALU_SCOREBOARD_EN to add mismatch/err_cnt reference checking.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int IDW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ALU_W-1:0] req_a,
  input  logic [ALU_W-1:0] req_b,
  input  logic [OPC_W-1:0] req_op,
  input  logic [IDW-1:0]   req_id,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OPC_W-1:0] alu_opcode,
  input  logic [ALU_W-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [IDW-1:0]   rsp_id,
  output logic             busy
`ifdef ALU_SCOREBOARD_EN
  ,
  output logic             mismatch,
  output logic [15:0]      err_cnt
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OPC_W-1:0] op;
    logic [IDW-1:0]   id;
  } req_t;

  fsm_state_t    state;
  logic [CW-1:0] cnt;
  logic [IDW-1:0] id_q;
  req_t          head;
  req_t          wdata;
  logic          full;
  logic          empty;
  logic          full_nxt;
  logic          push;
  logic          pop;
  logic          cap;

  assign wdata = '{a: req_a, b: req_b, op: req_op, id: req_id};
  assign push  = req_valid && req_ready;
  assign pop   = !empty &&
                 ((state == ST_IDLE) ||
                  (state == ST_RESP && rsp_ready));
  assign cap   = (state == ST_SETTLE) && (cnt == '0);
  assign busy  = (state != ST_IDLE) || !empty;

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wdata    (wdata),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .full_nxt (full_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      id_q       <= '0;
      req_ready  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
    end else begin
      req_ready <= !full_nxt;
      // pop is already qualified by state, so it doubles as "issue"
      if (pop) begin
        alu_a      <= head.a;
        alu_b      <= head.b;
        alu_opcode <= head.op;
        id_q       <= head.id;
        cnt        <= CW'(SETTLE - 1);
        state      <= ST_SETTLE;
      end
      unique case (state)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (cap) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (empty) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SCOREBOARD_EN
  logic [ALU_W:0] expv;
  logic           bad;

  assign expv = alu_ref(alu_a, alu_b, alu_op_e'(alu_opcode));
  assign bad  = cap && (expv != {alu_zero, alu_result});

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= bad;
      if (bad && err_cnt != 16'hFFFF) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and randomized-backpressure bench for alu_cmd_issuer.
// Build with ALU_SCOREBOARD_EN to also exercise mismatch/err_cnt.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [2:0] req_op;
  logic [3:0] req_id;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic [3:0] rsp_id;
  logic       busy;
  logic       alu_err;
`ifdef ALU_SCOREBOARD_EN
  logic       mismatch;
  logic [15:0] err_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  logic [12:0] q[$];

  always #5 clk = ~clk;

  alu_cmd_issuer #(
    .DEPTH(4), .SETTLE(1), .IDW(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_id     (req_id),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef ALU_SCOREBOARD_EN
    ,
    .mismatch   (mismatch),
    .err_cnt    (err_cnt)
`endif
  );

  function automatic logic [7:0] f_alu(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] op
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  // Combinational ALU, optionally off by one
  always_comb begin
    alu_result = f_alu(alu_a, alu_b, alu_opcode) + {7'd0, alu_err};
    alu_zero   = (alu_result == 8'd0);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one(
    string t, logic [7:0] a, logic [7:0] b, logic [2:0] op,
    logic [3:0] id, logic [7:0] er, logic ez, logic mm
  );
    req_a = a; req_b = b; req_op = op; req_id = id;
    req_valid = 1'b1;
    chk({t, "_rdy"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    tick();
    chk({t, "_alu"}, {alu_a, alu_b, alu_opcode}, {a, b, op});
    chk({t, "_early"}, rsp_valid, 0);
    tick();
    chk({t, "_vld"}, rsp_valid, 1);
    chk({t, "_rsp"}, {rsp_result, rsp_zero, rsp_id}, {er, ez, id});
`ifdef ALU_SCOREBOARD_EN
    chk({t, "_mm"}, mismatch, mm);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({t, "_done"}, rsp_valid, 0);
`ifdef ALU_SCOREBOARD_EN
    chk({t, "_mm0"}, mismatch, 0);
`else
    if (mm) $display("note: mm ignored");
`endif
  endtask

  task automatic outs_zero(string t);
    chk(t, {req_ready, alu_a, alu_b, alu_opcode, rsp_valid,
            rsp_result, rsp_zero, rsp_id, busy}, 64'd0);
  endtask

  initial begin
    int acc;
    int got;
    int last;
    logic stale;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_id = '0;
    alu_err = 1'b0;
    tick(); tick();
    outs_zero("rst_outs");
`ifdef ALU_SCOREBOARD_EN
    chk("rst_err", {mismatch, err_cnt}, 0);
`endif
    rst = 1'b0;
    tick();
    chk("rst_rdy", req_ready, 1);

    // single ops through each path
    one("add", 8'h0F, 8'h01, 3'd0, 4'd3, 8'h10, 1'b0, 1'b0);
    one("sub", 8'h55, 8'h55, 3'd1, 4'd7, 8'h00, 1'b1, 1'b0);
    one("and", 8'hF0, 8'h3C, 3'd2, 4'd1, 8'h30, 1'b0, 1'b0);
    one("not", 8'h0F, 8'h00, 3'd5, 4'd2, 8'hF0, 1'b0, 1'b0);
    one("shl", 8'h81, 8'h01, 3'd6, 4'd4, 8'h02, 1'b0, 1'b0);
    one("shr", 8'h80, 8'h03, 3'd7, 4'd5, 8'h10, 1'b0, 1'b0);

    // fill under backpressure, then drain
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_a = 8'(i * 16); req_b = 8'h01; req_op = 3'd0;
      req_id = 4'(i + 1);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    chk("fill_acc", acc, 5);
    chk("fill_rdy", req_ready, 0);
    repeat (3) tick();
    chk("hold", {rsp_valid, rsp_result, rsp_id}, {1'b1, 8'h01, 4'd1});
    rsp_ready = 1'b1;
    got = 0;
    last = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (rsp_valid) begin
        chk("drain_rsp", {rsp_id, rsp_result},
            {4'(got + 1), 8'(got * 16 + 1)});
        if (got > 0) chk("drain_gap", c - last, 2);
        last = c;
        got++;
      end
      tick();
    end
    chk("drain_cnt", got, 5);
    rsp_ready = 1'b0;
    chk("drain_idle", {busy, req_ready}, 2'b01);

    // random backpressure
    fork
      begin : prod
        int guard;
        logic ok;
        guard = 0;
        for (int k = 0; k < 200; k++) begin
          req_a = 8'($urandom); req_b = 8'($urandom);
          req_op = 3'($urandom); req_id = 4'(k);
          ok = 1'b0;
          while (!ok && guard < 20000) begin
            req_valid = ($urandom_range(0, 3) != 0);
            ok = req_valid && req_ready;
            if (ok) q.push_back({f_alu(req_a, req_b, req_op),
                                 f_alu(req_a, req_b, req_op) == 8'd0,
                                 req_id});
            tick();
            guard++;
          end
        end
        req_valid = 1'b0;
      end
      begin : cons
        int n;
        logic held;
        logic [13:0] saved;
        logic [12:0] e;
        n = 0;
        held = 1'b0;
        saved = '0;
        for (int c = 0; c < 20000 && n < 200; c++) begin
          if (held) chk("rnd_hold",
            {rsp_valid, rsp_result, rsp_zero, rsp_id}, saved);
          rsp_ready = 1'($urandom_range(0, 1));
          held = 1'b0;
          if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
              chk("rnd_extra", 0, 1);
            end else begin
              e = q.pop_front();
              chk("rnd_rsp", {rsp_result, rsp_zero, rsp_id}, e);
            end
            n++;
          end else if (rsp_valid) begin
            held = 1'b1;
            saved = {rsp_valid, rsp_result, rsp_zero, rsp_id};
          end
          tick();
        end
        chk("rnd_cnt", n, 200);
      end
    join
    rsp_ready = 1'b1;
    repeat (4) tick();
    chk("rnd_tail", {rsp_valid, busy, 32'(q.size())}, 0);
    rsp_ready = 1'b0;

    // reset while an op settles with three queued
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_a = 8'(i); req_b = 8'h02; req_op = 3'd0;
      req_id = 4'(i + 8);
      tick();
    end
    req_valid = 1'b0;
    chk("mid_vld", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("mid_settle", {rsp_valid, busy}, 2'b01);
    rst = 1'b1;
    tick();
    outs_zero("mid_outs");
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("mid_rdy", {req_ready, busy}, 2'b10);
    stale = 1'b0;
    repeat (20) begin
      if (rsp_valid || busy) stale = 1'b1;
      tick();
    end
    chk("mid_stale", stale, 0);
    rsp_ready = 1'b0;

`ifdef ALU_SCOREBOARD_EN
    alu_err = 1'b1;
    one("sb_bad", 8'hFF, 8'h01, 3'd0, 4'hA, 8'h01, 1'b0, 1'b1);
    chk("sb_cnt1", err_cnt, 1);
    alu_err = 1'b0;
`endif
    one("wrap", 8'hFF, 8'h01, 3'd0, 4'h9, 8'h00, 1'b1, 1'b0);
`ifdef ALU_SCOREBOARD_EN
    chk("sb_cnt2", err_cnt, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Sequential front end that acts as the initiator on the ALU port bundle (a, b, opcode in; result, zero out). It accepts operation requests over a valid/ready channel and buffers them in a small FIFO. It drives one operation at a time into the combinational ALU, waits a programmable settle time, then captures result/zero. Captured results are returned over a valid/ready response channel tagged with a request ID. This lets synthesizable stimulus and system logic use the ALU without a testbench driving its ports.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
SETTLE, 1, cycles between driving ALU inputs and sampling result (>=1)
IDW, 4, request/response tag width

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_a  in  8  operand A
req_b  in  8  operand B
req_op  in  3  opcode (alu_pkg::alu_op_e)
req_id  in  IDW  request tag
alu_a  out  8  to ALU a
alu_b  out  8  to ALU b
alu_opcode  out  3  to ALU opcode
alu_result  in  8  from ALU result
alu_zero  in  1  from ALU zero
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  8  captured result
rsp_zero  out  1  captured zero
rsp_id  out  IDW  tag of completed request
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (synchronous, rst high at clk edge): FIFO empty, FSM IDLE. All of the following are 0: req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_zero, rsp_id, busy, settle counter. req_ready rises the first cycle after rst deasserts.
- Request accept: a request is taken when req_valid && req_ready at the edge. req_ready = !full and is registered. Full means DEPTH entries stored. A push and pop in the same cycle when full is not permitted; req_ready stays low while full.
- FIFO: read and write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Empty when the pointers are equal. Full when the MSBs differ and the rest are equal.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head and register a/b/opcode onto alu_*. Load the settle counter with SETTLE-1, latch the id, go to SETTLE.
  - SETTLE: decrement the counter. At 0, capture alu_result/alu_zero into the rsp_* registers, set rsp_valid, go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready, clear rsp_valid. If the FIFO is non-empty, pop and issue directly (back-to-back, no IDLE bubble) into SETTLE; otherwise go to IDLE.
- alu_* outputs hold the last issued operation until the next issue. They are not zeroed between operations.
- Latency: with an empty FIFO, a request accepted at edge N drives alu_* after edge N+1. rsp_valid rises after edge N+1+SETTLE. SETTLE=1 gives rsp_valid 2 cycles after accept.
- Throughput with rsp_ready held high: one response per SETTLE+1 cycles.
- Simultaneous push into an empty FIFO and an IDLE pop: the entry is pushed and becomes visible to IDLE on the following cycle. There is no bypass path.
- Reset mid-operation: everything in flight is discarded. No response is produced for buffered or issuing requests.
- Responses are returned in request order, and the ID is passed through unchanged.

Optional Feature:
ALU_SCOREBOARD_EN. When defined, the block computes a reference result with alu_pkg::alu_ref() at capture time and compares it with alu_result/alu_zero. It adds two outputs: mismatch (1-bit, pulses for one cycle at capture) and err_cnt (16-bit, saturating, cleared by rst). When undefined, neither port nor the logic exists, and timing and handshake behaviour are identical.

Decomposition:
- alu_pkg holds:
  - alu_op_e enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7
  - ALU_W=8 and OPC_W=3
  - alu_req_t struct {a, b, op, id}
  - fsm state enum {IDLE, SETTLE, RESP}
  - alu_ref function (8-bit wrap, zero = result==0)
- Sub-module: alu_req_fifo (parameterized sync FIFO storing alu_req_t). Its outputs are full and empty.

Test Plan:
- Reset then single request a=8'h0F, b=8'h01, op=ADD, id=3 -> alu_a=0F, alu_b=01, alu_opcode=0 after the next edge; rsp_valid 2 cycles after accept with result=8'h10, zero=0, id=3.
- SUB a=8'h55, b=8'h55 -> rsp_result=8'h00, rsp_zero=1.
- Push 5 requests back-to-back with rsp_ready=0, DEPTH=4 -> 4 accepted plus 1 issued, then req_ready=0. The first response is held stable. Releasing rsp_ready drains ids in order, with no bubble between responses.
- Random rsp_ready backpressure over 200 ops -> responses in order, rsp_* never change while valid && !ready, no loss or duplication.
- Assert rst during SETTLE with 3 entries queued -> next cycle all outputs are 0, busy=0, and no stale response appears afterwards.
- With ALU_SCOREBOARD_EN, force alu_result off by one on ADD 8'hFF+8'h01 -> mismatch pulses and err_cnt=1. A correct ALU wrap gives result=00, zero=1, and no mismatch.
